// File: rtl/seven_segment_scan_if.sv
// Bundles the load/data request and the multiplexed display outputs of seven_segment_scan.
interface seven_segment_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [7:0]            display;
    logic [DIGITS-1:0]     an;
    logic                  frame;

    modport master (
        output load, value, dp,
        input  display, an, frame
    );

    modport slave (
        input  load, value, dp,
        output display, an, frame
    );
endinterface

// File: rtl/seven_segment_scan.sv
// Multiplexed hex seven-segment scanner with frame-synchronous double-buffered data.
// Define SEVSEG_LZB_EN to blank leading zero digits (digit 0 never blanks).
module seven_segment_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    seven_segment_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  frame_q;
    logic [4*DIGITS-1:0]   act_value;
    logic [4*DIGITS-1:0]   pend_value;
    logic [DIGITS-1:0]     act_dp;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_flag;
    logic [7:0]            display_q;
    logic [DIGITS-1:0]     an_q;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nibble;
    logic                  dp_bit;
    logic                  blank;
    logic [6:0]            seg;
    logic [7:0]            display_next;
    logic [DIGITS-1:0]     an_next;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= wrap;
            cnt     <= tick ? '0 : cnt + CW'(1);
            if (wrap)
                idx <= '0;
            else if (tick)
                idx <= idx + IW'(1);
        end
    end

    // New data only moves to the active copy at a wrap, so a frame never mixes old and new digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_value  <= '0;
            act_dp     <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_flag  <= 1'b0;
        end else begin
            if (wrap && pend_flag) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
            end
            if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp;
                pend_flag  <= 1'b1;
            end else if (wrap) begin
                pend_flag  <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble  = 4'h0;
        dp_bit  = 1'b0;
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nibble     = act_value[4*i +: 4];
                dp_bit     = act_dp[i];
                an_next[i] = 1'b0;
            end
        end
    end

`ifdef SEVSEG_LZB_EN
    logic [IW-1:0] msd;

    // Any digit above the highest nonzero nibble is a leading zero; an all-zero value keeps digit 0.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (act_value[4*i +: 4] != 4'h0)
                msd = IW'(i);
        end
        blank = (idx > msd);
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h67;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        if (blank)
            seg = 7'h00;
        display_next = {~dp_bit, ~seg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_q <= 8'hFF;
            an_q      <= '1;
        end else begin
            display_q <= display_next;
            an_q      <= an_next;
        end
    end

    assign bus.display = display_q;
    assign bus.an      = an_q;
    assign bus.frame   = frame_q;
endmodule
